// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage and the
// stage registers that reuse its IF/ID register.
package if_pkg;

  // addi x0,x0,0: the bubble placed in a stage register on reset or flush
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // REQ: request on the bus; WAIT: granted, awaiting data;
  // HOLD: data captured in skid while stalled; DRAIN: discard a flushed response
  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus: one outstanding request,
// req/gnt handshake followed by rvalid on a later cycle.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// Generic pipeline stage register holding {pc, inst, valid}.
// Flush and reset both insert a bubble; with neither load nor stall the
// valid bit drops so a stale instruction is never re-presented downstream.
module if_id_reg
  import if_pkg::*;
#(
  parameter logic [31:0] RST_INST = NOP_INST
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_load,
  input  logic   i_flush,
  input  logic   i_stall,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  // Bubble on reset/flush, capture on load, otherwise hold (stall) or invalidate
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_q <= '{pc: 32'h0, inst: RST_INST, valid: 1'b0};
    end else if (i_load) begin
      r_q <= i_d;
    end else if (!i_stall) begin
      r_q.valid <= 1'b0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the architectural PC, runs the fetch FSM
// against instruction memory, buffers a response that arrives during a
// stall, and feeds the IF/ID register. The next PC always comes from the
// external PC mux; this block never increments the PC itself.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        redirect,
  input  logic        stall,
  output logic [31:0] pc_out,
  if_stage_if.master  imem,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
);

  import if_pkg::*;

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_skid_pc;
  logic [31:0]  r_skid_inst;
  logic         r_skid_vld;

  logic         w_pc_load;
  logic         w_skid_load;
  logic         w_skid_clr;
  logic         w_ifid_load;
  logic         w_ifid_flush;
  if_id_t       w_ifid_d;
  if_id_t       w_ifid_q;

  // State and PC register; the PC only moves when an instruction retires
  // into IF/ID or on a redirect, so it is stable across REQ/WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= REQ;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (w_pc_load) r_pc <= pc_in;
    end
  end

  // Skid occupancy flag: set when a response lands during a stall
  always_ff @(posedge clk) begin
    if (rst || w_skid_clr) begin
      r_skid_vld <= 1'b0;
    end else if (w_skid_load) begin
      r_skid_vld <= 1'b1;
    end else if (w_ifid_load) begin
      r_skid_vld <= 1'b0;
    end
  end

  // Skid payload: only meaningful while the flag is set, so it needs no reset
  always_ff @(posedge clk) begin
    if (w_skid_load) begin
      r_skid_pc   <= r_pc;
      r_skid_inst <= imem.imem_rdata;
    end
  end

  // Next-state and control decode; redirect overrides stall and rvalid
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_load    = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_clr   = 1'b0;
    w_ifid_load  = 1'b0;
    w_ifid_flush = 1'b0;
    if (redirect) begin
      w_pc_load    = 1'b1;
      w_skid_clr   = 1'b1;
      w_ifid_flush = 1'b1;
      case (r_state)
        REQ:     if (imem.imem_gnt) w_state_nxt = DRAIN;
        WAIT:    w_state_nxt = imem.imem_rvalid ? REQ : DRAIN;
        HOLD:    w_state_nxt = REQ;
        DRAIN:   if (imem.imem_rvalid) w_state_nxt = REQ;
        default: w_state_nxt = REQ;
      endcase
    end else begin
      case (r_state)
        REQ: begin
          if (imem.imem_gnt) w_state_nxt = WAIT;
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            if (stall) begin
              w_skid_load = 1'b1;
              w_state_nxt = HOLD;
            end else begin
              w_ifid_load = 1'b1;
              w_pc_load   = 1'b1;
              w_state_nxt = REQ;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            w_ifid_load = 1'b1;
            w_pc_load   = 1'b1;
            w_state_nxt = REQ;
          end
        end
        DRAIN: begin
          if (imem.imem_rvalid) w_state_nxt = REQ;
        end
        default: w_state_nxt = REQ;
      endcase
    end
  end

  // IF/ID source: skid contents when releasing from HOLD, else the live response
  always_comb begin
    w_ifid_d.pc    = r_skid_vld ? r_skid_pc   : r_pc;
    w_ifid_d.inst  = r_skid_vld ? r_skid_inst : imem.imem_rdata;
    w_ifid_d.valid = 1'b1;
  end

  if_id_reg #(
    .RST_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_ifid_load),
    .i_flush (w_ifid_flush),
    .i_stall (stall),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign imem.imem_req  = (r_state == REQ) && !rst;
  assign imem.imem_addr = {r_pc[31:2], 2'b00};
  assign pc_out         = r_pc;
  assign if_id_pc       = w_ifid_q.pc;
  assign if_id_inst     = w_ifid_q.inst;
  assign if_id_valid    = w_ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: the bench plays both instruction memory and PC mux.
// Expected IF/ID contents are queued when a response is driven and popped
// when IF/ID reports a valid instruction.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        redirect;
  logic        stall;
  logic [31:0] pc_out;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;

  if_stage_if mem ();

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .redirect    (redirect),
    .stall       (stall),
    .pc_out      (pc_out),
    .imem        (mem),
    .if_id_pc    (if_id_pc),
    .if_id_inst  (if_id_inst),
    .if_id_valid (if_id_valid)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one complete fetch (grant then response) and queue the expectation
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
    mem.imem_gnt = 1'b1;
    pc_in        = pc + 32'd4;
    cyc();
    mem.imem_gnt    = 1'b0;
    mem.imem_rvalid = 1'b1;
    mem.imem_rdata  = data;
    sb.push_back('{pc: pc, inst: data});
    cyc();
    mem.imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    vectors++;
    if (pc_out !== 32'h0) begin
      miscompares++; $display("FAIL reset_pc got %h want %h", pc_out, 32'h0);
    end
    vectors++;
    if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_inst !== NOP) begin
      miscompares++;
      $display("FAIL reset_ifid got %b/%h/%h want 0/00000000/%h", if_id_valid, if_id_pc, if_id_inst, NOP);
    end
    vectors++;
    if (mem.imem_req !== 1'b0) begin
      miscompares++; $display("FAIL reset_req got %b want 0", mem.imem_req);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (mem.imem_req !== 1'b1 || mem.imem_addr !== 32'h0) begin
      miscompares++; $display("FAIL post_reset_req got %b/%h want 1/00000000", mem.imem_req, mem.imem_addr);
    end
  endtask

  task automatic test_free_run();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] p;
      p = 32'(k * 4);
      vectors++;
      if (mem.imem_req !== 1'b1 || mem.imem_addr !== p) begin
        miscompares++; $display("FAIL run_addr got %b/%h want 1/%h", mem.imem_req, mem.imem_addr, p);
      end
      fetch(p, 32'h0010_0093);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++; $display("FAIL run_sb queue empty");
      end else begin
        e = sb.pop_front();
        if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_inst !== e.inst) begin
          miscompares++;
          $display("FAIL run_ifid got %b/%h/%h want 1/%h/%h", if_id_valid, if_id_pc, if_id_inst, e.pc, e.inst);
        end
      end
      vectors++;
      if (pc_out !== p + 32'd4) begin
        miscompares++; $display("FAIL run_pc got %h want %h", pc_out, p + 32'd4);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    vectors++;
    if (mem.imem_addr !== 32'h8) begin
      miscompares++; $display("FAIL stall_addr got %h want 00000008", mem.imem_addr);
    end
    mem.imem_gnt = 1'b1;
    pc_in        = 32'hC;
    cyc();
    mem.imem_gnt    = 1'b0;
    mem.imem_rvalid = 1'b1;
    mem.imem_rdata  = 32'h0020_0113;
    stall           = 1'b1;
    sb.push_back('{pc: 32'h8, inst: 32'h0020_0113});
    for (int i = 0; i < 3; i++) begin
      cyc();
      mem.imem_rvalid = 1'b0;
      vectors++;
      if (if_id_valid !== 1'b0 || if_id_pc !== 32'h4 || if_id_inst !== 32'h0010_0093 ||
          pc_out !== 32'h8 || mem.imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold got v=%b pc=%h inst=%h pco=%h req=%b want 0/4/00100093/8/0",
                 if_id_valid, if_id_pc, if_id_inst, pc_out, mem.imem_req);
      end
    end
    stall = 1'b0;
    cyc();
    vectors++;
    if (sb.size() == 0) begin
      miscompares++; $display("FAIL stall_sb queue empty");
    end else begin
      e = sb.pop_front();
      if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_inst !== e.inst) begin
        miscompares++;
        $display("FAIL stall_release got %b/%h/%h want 1/%h/%h", if_id_valid, if_id_pc, if_id_inst, e.pc, e.inst);
      end
    end
    vectors++;
    if (pc_out !== 32'hC || mem.imem_addr !== 32'hC || mem.imem_req !== 1'b1) begin
      miscompares++; $display("FAIL stall_next got %h/%h/%b want c/c/1", pc_out, mem.imem_addr, mem.imem_req);
    end
  endtask

  task automatic test_redirect_wait();
    mem.imem_gnt = 1'b1;
    pc_in        = 32'h10;
    cyc();
    mem.imem_gnt = 1'b0;
    redirect     = 1'b1;
    pc_in        = 32'h100;
    cyc();
    redirect = 1'b0;
    vectors++;
    if (if_id_valid !== 1'b0 || if_id_inst !== NOP || if_id_pc !== 32'h0 ||
        pc_out !== 32'h100 || mem.imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_flush got v=%b inst=%h pc=%h pco=%h req=%b want 0/%h/0/100/0",
               if_id_valid, if_id_inst, if_id_pc, pc_out, mem.imem_req, NOP);
    end
    mem.imem_rvalid = 1'b1;
    mem.imem_rdata  = 32'hBAD0_0BAD;
    pc_in           = 32'h104;
    cyc();
    mem.imem_rvalid = 1'b0;
    vectors++;
    if (if_id_valid !== 1'b0 || pc_out !== 32'h100 || mem.imem_req !== 1'b1 || mem.imem_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL redir_drain got v=%b pco=%h req=%b addr=%h want 0/100/1/100",
               if_id_valid, pc_out, mem.imem_req, mem.imem_addr);
    end
  endtask

  task automatic test_redirect_stall();
    exp_t e;
    mem.imem_gnt = 1'b1;
    pc_in        = 32'h104;
    cyc();
    mem.imem_gnt    = 1'b0;
    mem.imem_rvalid = 1'b1;
    mem.imem_rdata  = 32'h1234_5678;
    stall           = 1'b1;
    redirect        = 1'b1;
    pc_in           = 32'h200;
    cyc();
    mem.imem_rvalid = 1'b0;
    stall           = 1'b0;
    redirect        = 1'b0;
    vectors++;
    if (if_id_valid !== 1'b0 || if_id_inst !== NOP || pc_out !== 32'h200 ||
        mem.imem_req !== 1'b1 || mem.imem_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL redir_stall got v=%b inst=%h pco=%h req=%b addr=%h want 0/%h/200/1/200",
               if_id_valid, if_id_inst, pc_out, mem.imem_req, mem.imem_addr, NOP);
    end
    fetch(32'h200, 32'h0030_0193);
    vectors++;
    if (sb.size() == 0) begin
      miscompares++; $display("FAIL redir_stall_sb queue empty");
    end else begin
      e = sb.pop_front();
      if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_inst !== e.inst) begin
        miscompares++;
        $display("FAIL redir_refetch got %b/%h/%h want 1/%h/%h", if_id_valid, if_id_pc, if_id_inst, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    mem.imem_gnt = 1'b0;
    pc_in        = 32'h208;
    for (int i = 0; i < 5; i++) begin
      cyc();
      vectors++;
      if (mem.imem_req !== 1'b1 || mem.imem_addr !== 32'h204 || if_id_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_cycle%0d got req=%b addr=%h v=%b want 1/204/0", i, mem.imem_req, mem.imem_addr, if_id_valid);
      end
    end
    fetch(32'h204, 32'h0040_0213);
    vectors++;
    if (sb.size() == 0) begin
      miscompares++; $display("FAIL bp_sb queue empty");
    end else begin
      e = sb.pop_front();
      if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_inst !== e.inst) begin
        miscompares++;
        $display("FAIL bp_fetch got %b/%h/%h want 1/%h/%h", if_id_valid, if_id_pc, if_id_inst, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    mem.imem_gnt = 1'b1;
    pc_in        = 32'h20C;
    cyc();
    mem.imem_gnt = 1'b0;
    rst          = 1'b1;
    cyc();
    vectors++;
    if (pc_out !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc !== 32'h0 ||
        if_id_inst !== NOP || mem.imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rstw_state got pco=%h v=%b pc=%h inst=%h req=%b want 0/0/0/%h/0",
               pc_out, if_id_valid, if_id_pc, if_id_inst, mem.imem_req, NOP);
    end
    mem.imem_rvalid = 1'b1;
    mem.imem_rdata  = 32'hDEAD_BEEF;
    cyc();
    mem.imem_rvalid = 1'b0;
    rst             = 1'b0;
    #1;
    vectors++;
    if (mem.imem_req !== 1'b1 || mem.imem_addr !== 32'h0) begin
      miscompares++; $display("FAIL rstw_req got %b/%h want 1/00000000", mem.imem_req, mem.imem_addr);
    end
    mem.imem_rvalid = 1'b1;
    cyc();
    mem.imem_rvalid = 1'b0;
    vectors++;
    if (if_id_valid !== 1'b0 || pc_out !== 32'h0 || mem.imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rstw_late got v=%b pco=%h req=%b want 0/0/1", if_id_valid, pc_out, mem.imem_req);
    end
    fetch(32'h0, 32'h0050_0293);
    vectors++;
    if (sb.size() == 0) begin
      miscompares++; $display("FAIL rstw_sb queue empty");
    end else begin
      e = sb.pop_front();
      if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_inst !== e.inst || pc_out !== 32'h4) begin
        miscompares++;
        $display("FAIL rstw_refetch got %b/%h/%h pco=%h want 1/%h/%h pco=4",
                 if_id_valid, if_id_pc, if_id_inst, pc_out, e.pc, e.inst);
      end
    end
  endtask

  task automatic test_wrap_align();
    exp_t e;
    redirect = 1'b1;
    pc_in    = 32'h303;
    cyc();
    redirect = 1'b0;
    vectors++;
    if (pc_out !== 32'h303 || mem.imem_addr !== 32'h300 || mem.imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL align got pco=%h addr=%h req=%b want 303/300/1", pc_out, mem.imem_addr, mem.imem_req);
    end
    redirect = 1'b1;
    pc_in    = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    fetch(32'hFFFF_FFFC, 32'h0060_0313);
    vectors++;
    if (sb.size() == 0) begin
      miscompares++; $display("FAIL wrap_sb queue empty");
    end else begin
      e = sb.pop_front();
      if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_inst !== e.inst) begin
        miscompares++;
        $display("FAIL wrap_ifid got %b/%h/%h want 1/%h/%h", if_id_valid, if_id_pc, if_id_inst, e.pc, e.inst);
      end
    end
    vectors++;
    if (pc_out !== 32'h0 || mem.imem_addr !== 32'h0) begin
      miscompares++; $display("FAIL wrap_pc got %h/%h want 0/0", pc_out, mem.imem_addr);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL sb_leftover got %0d want 0", sb.size());
    end
  endtask

  initial begin
    rst             = 1'b1;
    pc_in           = 32'h0;
    redirect        = 1'b0;
    stall           = 1'b0;
    mem.imem_gnt    = 1'b0;
    mem.imem_rvalid = 1'b0;
    mem.imem_rdata  = 32'h0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_backpressure();
    test_reset_mid_wait();
    test_wrap_align();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline.
- Owns the architectural PC register, whose output drives PC_MUX, and loads PC_MUX's `pc_in` as the next PC.
- Issues one-outstanding-request fetches to instruction memory over a req/gnt/rvalid handshake.
- Delivers {pc, inst, valid} into the IF/ID pipeline register, with stall (hazard unit) and flush (redirect from EX) handling.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction word placed in IF/ID on reset/flush (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pc_in  in  32  next PC from PC_MUX (pc_out+4 or redirect target)
- redirect  in  1  br_taken | is_JAL | is_JALR from EX; flushes fetch and IF/ID
- stall  in  1  hazard-unit stall; IF/ID and PC must hold
- pc_out  out  32  current fetch PC; feeds PC_MUX
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (= pc_out, word aligned)
- imem_gnt  in  1  memory accepted request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  fetched instruction
- if_id_pc  out  32  PC of instruction in IF/ID
- if_id_inst  out  32  instruction in IF/ID
- if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- **Reset (rst=1 at posedge):**
  - pc_out=RESET_PC, state=REQ, if_id_valid=0, if_id_pc=0, if_id_inst=NOP_INST, skid buffer empty, drop flag clear.
  - imem_req forced 0 while rst=1.
  - Reset mid-request abandons it; any late rvalid after reset is ignored until a new grant occurs.
- **States:** REQ, WAIT, HOLD, DRAIN.
- **REQ:**
  - imem_req=1, imem_addr=pc_out.
  - gnt=1 → WAIT; otherwise stay.
  - pc_out is stable throughout REQ/WAIT.
- **WAIT:**
  - imem_req=0. rvalid is never accepted in the same cycle as gnt; earliest is the cycle after.
  - rvalid & !stall → IF/ID <= {pc_out, rdata, 1}, pc_out <= pc_in, → REQ.
  - rvalid & stall → skid <= {pc_out, rdata}, → HOLD. IF/ID and pc_out hold.
- **HOLD:**
  - imem_req=0.
  - !stall → IF/ID <= skid with valid=1, pc_out <= pc_in, → REQ.
- **DRAIN:**
  - imem_req=0; wait for the outstanding rvalid, discard its data, → REQ.
- **IF/ID when no instruction is delivered in a cycle:**
  - stall=1 → hold all fields.
  - stall=0 → if_id_valid <= 0; pc/inst may hold.
- **redirect=1** (priority over stall and over rvalid in the same cycle):
  - pc_out <= pc_in (target).
  - IF/ID <= {0, NOP_INST, 0}; skid cleared.
  - State update:
    - from REQ with gnt=1 → DRAIN;
    - from REQ with gnt=0 → REQ;
    - from WAIT without rvalid → DRAIN;
    - from WAIT with rvalid → REQ (data dropped);
    - from HOLD → REQ;
    - from DRAIN → stay DRAIN unless rvalid, then REQ.
- **Throughput:** best case one instruction per 2 cycles (REQ+gnt, then rvalid).
- **Latency:** rvalid at cycle N makes IF/ID visible at N+1.
- **PC arithmetic:**
  - pc_out is a plain 32-bit register with no increment inside this block (PC_MUX adds 4).
  - Wrap 32'hFFFF_FFFC → 0 is PC_MUX's result and is accepted unchanged.
  - imem_addr[1:0] is driven 0.
- **Simultaneous stall & redirect:** redirect wins. The flush is performed and the stall is ignored for that cycle.

Decomposition:
- **Package if_pkg:**
  - fetch_state_e enum {REQ, WAIT, HOLD, DRAIN};
  - NOP_INST constant;
  - if_id_t struct {pc, inst, valid}.
- **Sub-module if_id_reg:** the IF/ID register with load/hold/flush controls and reset to {0, NOP_INST, 0]. It is reused by later stage registers.
- FSM, PC register and skid buffer stay in if_stage.

Test Plan:
- **Reset then free run:** rst 2 cycles, gnt=1 every REQ, rvalid next cycle with rdata=32'h0010_0093; pc_in=pc_out+4 → imem_addr sequence 0,4,8; IF/ID shows pc=0 inst=0x00100093 valid=1 one cycle after first rvalid.
- **Stall on response:** stall=1 in the rvalid cycle for pc=8, held 3 cycles → state HOLD, IF/ID unchanged, pc_out=8. After stall drops, IF/ID={8, data, 1} next cycle and imem_addr=0xC.
- **Redirect during WAIT:** redirect=1, pc_in=0x100 before rvalid → IF/ID valid=0 inst=NOP; late rvalid data discarded; next imem_addr=0x100.
- **Redirect and stall same cycle with rvalid:** flush wins → IF/ID valid=0, pc_out=target, no HOLD entry.
- **Memory backpressure:** gnt low 5 cycles in REQ → imem_req stays 1, imem_addr stable, if_id_valid=0 after first bubble cycle.
- **Reset mid-WAIT:** rst pulsed while outstanding → pc_out=RESET_PC, IF/ID={0, NOP, 0}, imem_req=0 during rst, refetch from 0 afterwards.
